// File: rtl/rv32i_pkg.sv
// Shared rv32i types: the machine word, cache line geometry defaults and the
// memory arbiter state encoding.
package rv32i_pkg;

    typedef logic [31:0] rv32i_word;

    localparam int LINE_BITS_DEFAULT = 256;
    localparam int BEAT_BITS_DEFAULT = 64;
    localparam int LINE_OFFSET_BITS  = 5;

    typedef enum logic [2:0] {
        IDLE,
        I_RD,
        D_RD,
        D_WR,
        DONE
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_line_buffer.sv
// Line assembler/serializer: collects read beats into a full cache line and
// presents the beat selected by the burst counter for write bursts.
module line_buffer
    import rv32i_pkg::*;
#(
    parameter int LINE_BITS = LINE_BITS_DEFAULT,
    parameter int BEAT_BITS = BEAT_BITS_DEFAULT,
    localparam int BEATS    = LINE_BITS / BEAT_BITS,
    localparam int IDX_BITS = $clog2(BEATS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [LINE_BITS-1:0] i_loadLine,
    input  logic                 i_capture,
    input  logic [IDX_BITS-1:0]  i_index,
    input  logic [BEAT_BITS-1:0] i_beat,
    output logic [LINE_BITS-1:0] o_line,
    output logic [BEAT_BITS-1:0] o_beat
);

    logic [LINE_BITS-1:0] r_line;

    // A write grant loads the whole line; read beats overwrite one slot each.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_line <= '0;
        end else if (i_load) begin
            r_line <= i_loadLine;
        end else if (i_capture) begin
            r_line[int'(i_index)*BEAT_BITS +: BEAT_BITS] <= i_beat;
        end
    end

    assign o_line = r_line;
    assign o_beat = r_line[int'(i_index)*BEAT_BITS +: BEAT_BITS];

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the instruction and data caches for a single
// burst-oriented physical memory port.
module mem_arbiter
    import rv32i_pkg::*;
#(
    parameter int LINE_BITS = LINE_BITS_DEFAULT,
    parameter int BEAT_BITS = BEAT_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 i_read,
    input  logic [31:0]          i_addr,
    output logic [LINE_BITS-1:0] i_rdata,
    output logic                 i_resp,

    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [31:0]          d_addr,
    input  logic [LINE_BITS-1:0] d_wdata,
    output logic [LINE_BITS-1:0] d_rdata,
    output logic                 d_resp,

    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [31:0]          pmem_addr,
    output logic [BEAT_BITS-1:0] pmem_wdata,
    input  logic [BEAT_BITS-1:0] pmem_rdata,
    input  logic                 pmem_resp
);

    localparam int BEATS    = LINE_BITS / BEAT_BITS;
    localparam int IDX_BITS = $clog2(BEATS);
    localparam logic [IDX_BITS-1:0] LAST_BEAT = IDX_BITS'(BEATS - 1);

    arb_state_t            r_state;
    logic [IDX_BITS-1:0]   r_count;
    logic                  r_prioInstr;
    rv32i_word             r_addr;

    logic                  w_dataReq;
    logic                  w_grantInstr;
    logic                  w_grantData;
    logic                  w_readBurst;
    logic [LINE_BITS-1:0]  w_line;
    logic [BEAT_BITS-1:0]  w_beat;

    assign w_dataReq = d_read | d_write;

    always_comb begin
        w_grantInstr = 1'b0;
        w_grantData  = 1'b0;
        if (r_state == IDLE) begin
            if (i_read && w_dataReq) begin
                w_grantInstr = r_prioInstr;
                w_grantData  = ~r_prioInstr;
            end else begin
                w_grantInstr = i_read;
                w_grantData  = w_dataReq;
            end
        end
    end

    // r_prioInstr doubles as a record of who was served: it is cleared on an
    // instruction grant and set on a data grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_prioInstr <= 1'b1;
            r_addr      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_count <= '0;
                    if (w_grantInstr) begin
                        r_state     <= I_RD;
                        r_addr      <= {i_addr[31:LINE_OFFSET_BITS], LINE_OFFSET_BITS'(0)};
                        r_prioInstr <= 1'b0;
                    end else if (w_grantData) begin
                        r_state     <= d_write ? D_WR : D_RD;
                        r_addr      <= {d_addr[31:LINE_OFFSET_BITS], LINE_OFFSET_BITS'(0)};
                        r_prioInstr <= 1'b1;
                    end
                end
                I_RD, D_RD, D_WR: begin
                    if (pmem_resp) begin
                        r_count <= r_count + 1'b1;
                        if (r_count == LAST_BEAT) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_readBurst = (r_state == I_RD) || (r_state == D_RD);

    line_buffer #(
        .LINE_BITS (LINE_BITS),
        .BEAT_BITS (BEAT_BITS)
    ) u_lineBuffer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_grantData & d_write),
        .i_loadLine (d_wdata),
        .i_capture  (w_readBurst & pmem_resp),
        .i_index    (r_count),
        .i_beat     (pmem_rdata),
        .o_line     (w_line),
        .o_beat     (w_beat)
    );

    assign pmem_read  = w_readBurst;
    assign pmem_write = (r_state == D_WR);
    assign pmem_addr  = r_addr;
    assign pmem_wdata = w_beat;
    assign i_resp     = (r_state == DONE) && !r_prioInstr;
    assign d_resp     = (r_state == DONE) && r_prioInstr;
    assign i_rdata    = w_line;
    assign d_rdata    = w_line;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: a behavioural memory answers
// bursts with optional gaps between beats.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_addr;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_addr;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_addr;
    logic [63:0]  pmem_wdata;
    logic [63:0]  pmem_rdata;
    logic         pmem_resp;

    int checks   = 0;
    int failures = 0;

    mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .i_read     (i_read),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_addr  (pmem_addr),
        .pmem_wdata (pmem_wdata),
        .pmem_rdata (pmem_rdata),
        .pmem_resp  (pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic dr, input logic dw,
                                 input logic [31:0] ia, input logic [31:0] da, input logic [255:0] wd);
        i_read  = ir;
        d_read  = dr;
        d_write = dw;
        i_addr  = ia;
        d_addr  = da;
        d_wdata = wd;
    endtask

    // Waits for a grant, answers four beats (each preceded by 'gap' idle
    // cycles) and checks the one-cycle completion pulse.
    task automatic serviceBurst(input string tag, input logic [255:0] rdLine, input int gap,
                                input bit expWrite, input logic [31:0] expAddr, input bit expInstr,
                                input bit keepReq, output logic [255:0] wrSeen, output int waitCycles);
        bit granted;
        granted    = 1'b0;
        waitCycles = 0;
        wrSeen     = '0;
        for (int n = 1; n <= 20 && !granted; n++) begin
            @(posedge clk); #1;
            if (pmem_read || pmem_write) begin
                granted    = 1'b1;
                waitCycles = n;
            end
        end
        if (!granted) begin
            checkOutput({tag, " grant timeout"}, 256'(0), 256'(1));
            return;
        end
        checkOutput({tag, " pmem_write"}, 256'(pmem_write), 256'(expWrite));
        checkOutput({tag, " pmem_read"}, 256'(pmem_read), 256'(!expWrite));
        checkOutput({tag, " pmem_addr"}, 256'(pmem_addr), 256'(expAddr));
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap; g++) begin
                pmem_resp = 1'b0;
                @(posedge clk); #1;
                checkOutput({tag, " held during gap"}, 256'({pmem_read, pmem_write, i_resp | d_resp}),
                            256'({!expWrite, expWrite, 1'b0}));
            end
            pmem_resp  = 1'b1;
            pmem_rdata = rdLine[k*64 +: 64];
            wrSeen[k*64 +: 64] = pmem_wdata;
            @(posedge clk); #1;
            pmem_resp  = 1'b0;
            pmem_rdata = '0;
        end
        checkOutput({tag, " i_resp"}, 256'(i_resp), 256'(expInstr));
        checkOutput({tag, " d_resp"}, 256'(d_resp), 256'(!expInstr));
        checkOutput({tag, " pmem idle in done"}, 256'(pmem_read | pmem_write), 256'(0));
        if (!expWrite) begin
            checkOutput({tag, " rdata"}, expInstr ? i_rdata : d_rdata, rdLine);
        end
        if (!keepReq) begin
            applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        end
        @(posedge clk); #1;
        checkOutput({tag, " resp one pulse"}, 256'(i_resp | d_resp), 256'(0));
    endtask

    localparam logic [255:0] LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] LINE_B = {64'hDEAD_0000_0000_0004, 64'hDEAD_0000_0000_0003,
                                       64'hDEAD_0000_0000_0002, 64'hDEAD_0000_0000_0001};
    localparam logic [255:0] LINE_C = {64'h0C0C_0C0C_0000_0004, 64'h0C0C_0C0C_0000_0003,
                                       64'h0C0C_0C0C_0000_0002, 64'h0C0C_0C0C_0000_0001};
    localparam logic [255:0] WR_LINE = {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
                                        64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};
    localparam logic [255:0] WR_LINE2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                         64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0};

    initial begin
        logic [255:0] seen;
        int           wc;
        bit           sawActivity;

        rst        = 1'b0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset pmem strobes", 256'({pmem_read, pmem_write}), 256'(0));
        checkOutput("reset pmem_addr", 256'(pmem_addr), 256'(0));
        checkOutput("reset resp", 256'({i_resp, d_resp}), 256'(0));
        checkOutput("reset line", i_rdata, 256'(0));
        rst = 1'b1;
        @(posedge clk); #1;

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0064, '0, '0);
        serviceBurst("ifetch", LINE_A, 0, 1'b0, 32'h0000_0060, 1'b1, 1'b0, seen, wc);
        checkOutput("ifetch latency", 256'(wc), 256'(1));
        checkOutput("ifetch rdata stable", i_rdata, LINE_A);

        pmem_resp = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        checkOutput("idle resp ignored", 256'({pmem_read, pmem_write, i_resp, d_resp}), 256'(0));

        applyStimulus(1'b0, 1'b0, 1'b1, '0, 32'h8000_0020, WR_LINE);
        serviceBurst("dwrite", '0, 0, 1'b1, 32'h8000_0020, 1'b0, 1'b0, seen, wc);
        checkOutput("dwrite beats", seen, WR_LINE);

        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_2040, '0);
        serviceBurst("rr1 instr", LINE_B, 0, 1'b0, 32'h0000_1000, 1'b1, 1'b1, seen, wc);
        serviceBurst("rr2 data", LINE_C, 0, 1'b0, 32'h0000_2040, 1'b0, 1'b1, seen, wc);
        serviceBurst("rr3 instr", LINE_A, 0, 1'b0, 32'h0000_1000, 1'b1, 1'b1, seen, wc);
        serviceBurst("rr4 data", LINE_B, 0, 1'b0, 32'h0000_2040, 1'b0, 1'b0, seen, wc);

        applyStimulus(1'b0, 1'b1, 1'b0, '0, 32'h0000_0344, '0);
        serviceBurst("gap dread", LINE_C, 3, 1'b0, 32'h0000_0340, 1'b0, 1'b0, seen, wc);

        applyStimulus(1'b0, 1'b1, 1'b1, '0, 32'h0000_00BF, WR_LINE2);
        serviceBurst("rw as write", '0, 0, 1'b1, 32'h0000_00A0, 1'b0, 1'b0, seen, wc);
        checkOutput("rw as write beats", seen, WR_LINE2);

        applyStimulus(1'b0, 1'b1, 1'b0, '0, 32'h0000_4000, '0);
        @(posedge clk); #1;
        checkOutput("abort grant", 256'(pmem_read), 256'(1));
        for (int k = 0; k < 2; k++) begin
            pmem_resp  = 1'b1;
            pmem_rdata = LINE_B[k*64 +: 64];
            @(posedge clk); #1;
        end
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        rst = 1'b0;
        #1;
        checkOutput("abort outputs cleared",
                    256'({pmem_read, pmem_write, i_resp, d_resp, pmem_addr, pmem_wdata}), 256'(0));
        checkOutput("abort line cleared", d_rdata, 256'(0));
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        sawActivity = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            sawActivity |= (i_resp | d_resp | pmem_read | pmem_write);
        end
        checkOutput("no resp after abort", 256'(sawActivity), 256'(0));

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_5008, '0, '0);
        serviceBurst("post-reset ifetch", LINE_A, 0, 1'b0, 32'h0000_5000, 1'b1, 1'b0, seen, wc);
        checkOutput("post-reset latency", 256'(wc), 256'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
